// File: rtl/conv3x3_seq_ctrl.sv
// Sequencer for one 3x3 valid-padding convolution pass on pe_tensor: loads the filter,
// walks all output positions in raster order, and streams psum results through a credited FIFO.
module conv3x3_seq_ctrl #(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int PE_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [71:0]                filter_in,
  output logic                       busy,
  output logic                       done,
  output logic [71:0]                tensor_filter,
  output logic                       tensor_wb_write_en,
  output logic                       win_req,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  input  logic                       win_ack,
  input  logic [15:0]                tensor_psum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_data,
  output logic                       out_last
);

  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [CNTW-1:0]   fifo_count;
  logic [CNTW-1:0]   inflight_count;
  logic [PE_LAT-1:0] pipe_v;
  logic [PE_LAT-1:0] pipe_l;
  logic [16:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              issue;
  logic              push;
  logic              pop;
  logic              last_win;
  logic              col_wrap;

  // Credit: results already queued plus those still inside the PE never exceed FIFO space.
  always_comb begin
    win_req   = (state == RUN) &&
                (({1'b0, fifo_count} + {1'b0, inflight_count}) < (CNTW+1)'(FIFO_DEPTH));
    issue     = win_req && win_ack;
    col_wrap  = (win_col == CW'(IMG_W - 3));
    last_win  = (win_row == RW'(IMG_H - 3)) && col_wrap;
    push      = pipe_v[PE_LAT-1];
    out_valid = (fifo_count != '0);
    pop       = out_valid && out_ready;
    {out_last, out_data} = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      tensor_wb_write_en <= 1'b0;
      tensor_filter      <= '0;
      win_row            <= '0;
      win_col            <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            tensor_filter      <= filter_in;
            tensor_wb_write_en <= 1'b1;
            busy               <= 1'b1;
            state              <= LOAD_W;
          end
        end
        LOAD_W: begin
          tensor_wb_write_en <= 1'b0;
          state              <= RUN;
        end
        RUN: begin
          if (issue) begin
            if (last_win) begin
              win_row <= '0;
              win_col <= '0;
              state   <= DRAIN;
            end else if (col_wrap) begin
              win_col <= '0;
              win_row <= win_row + RW'(1);
            end else begin
              win_col <= win_col + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (fifo_count == '0 && inflight_count == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_v         <= '0;
      pipe_l         <= '0;
      inflight_count <= '0;
      fifo_count     <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      // Shift form works for PE_LAT == 1, where the pipe is a single stage.
      pipe_v <= (pipe_v << 1) | PE_LAT'(issue);
      pipe_l <= (pipe_l << 1) | PE_LAT'(issue && last_win);

      unique case ({issue, push})
        2'b10:   inflight_count <= inflight_count + CNTW'(1);
        2'b01:   inflight_count <= inflight_count - CNTW'(1);
        default: inflight_count <= inflight_count;
      endcase

      if (push) begin
        mem[wr_ptr] <= {pipe_l[PE_LAT-1], tensor_psum};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);

      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNTW'(1);
        2'b01:   fifo_count <= fifo_count - CNTW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_seq_ctrl.sv
// Directed bench for conv3x3_seq_ctrl: 8x8 image, PE_LAT=1, 4-entry FIFO, with a behavioural
// pe_tensor/line-buffer stand-in producing either the filter sum or an encoded window index.
module tb_conv3x3_seq_ctrl;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int FD = 4;
  localparam int NRES = (W - 2) * (H - 2);

  logic        clk;
  logic        rst;
  logic        start;
  logic [71:0] filter_in;
  logic        busy;
  logic        done;
  logic [71:0] tensor_filter;
  logic        tensor_wb_write_en;
  logic        win_req;
  logic [2:0]  win_row;
  logic [2:0]  win_col;
  logic        win_ack;
  logic [15:0] tensor_psum;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  conv3x3_seq_ctrl #(.IMG_W(W), .IMG_H(H), .PE_LAT(1), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .filter_in(filter_in),
    .busy(busy), .done(done), .tensor_filter(tensor_filter),
    .tensor_wb_write_en(tensor_wb_write_en), .win_req(win_req),
    .win_row(win_row), .win_col(win_col), .win_ack(win_ack),
    .tensor_psum(tensor_psum), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // stimulus controls (written only by the main initial block)
  int psum_mode = 0;
  bit ack_rnd   = 1'b0;

  // collected observations (written only by the negedge monitor)
  logic [15:0] res_q[$];
  bit          last_q[$];
  int          iss_row_q[$];
  int          iss_col_q[$];
  int cyc = 0, done_cnt = 0, wb_cnt = 0, outst = 0, hold_err = 0;
  int done_cyc = 0, last_pop_cyc = 0;
  bit ovf_flag = 1'b0;
  bit prev_stall = 1'b0;
  logic [2:0] prev_row, prev_col;

  localparam logic [71:0] F1 = {9{8'h01}};
  localparam logic [71:0] F2 = {9{8'h02}};

  initial begin
    win_ack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      win_ack = ack_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // pe_tensor stand-in: psum valid exactly one cycle after the window is applied
  always @(posedge clk) begin
    int s;
    if (rst && win_req && win_ack) begin
      if (psum_mode == 0) begin
        s = 0;
        for (int k = 0; k < 9; k++) s = s + int'($signed(tensor_filter[8*k +: 8]));
        tensor_psum <= 16'(s);
      end else begin
        tensor_psum <= 16'(16 * int'(win_row) + int'(win_col));
      end
    end else begin
      tensor_psum <= 16'hDEAD;
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      outst <= 0;
    end else begin
      if (win_req && win_ack) begin
        iss_row_q.push_back(int'(win_row));
        iss_col_q.push_back(int'(win_col));
      end
      if (out_valid && out_ready) begin
        res_q.push_back(out_data);
        last_q.push_back(out_last);
        if (out_last) last_pop_cyc <= cyc;
      end
      outst    <= outst + int'(win_req && win_ack) - int'(out_valid && out_ready);
      ovf_flag <= ovf_flag || ((outst + int'(win_req && win_ack) - int'(out_valid && out_ready)) > FD);
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (tensor_wb_write_en) wb_cnt <= wb_cnt + 1;
      if (prev_stall && (win_row !== prev_row || win_col !== prev_col)) hold_err <= hold_err + 1;
    end
    prev_stall <= rst && win_req && !win_ack;
    prev_row   <= win_row;
    prev_col   <= win_col;
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_pass(input string tag, input logic [71:0] filt);
    @(posedge clk);
    #1;
    start     = 1'b1;
    filter_in = filt;
    @(posedge clk);
    #1;
    start     = 1'b0;
    filter_in = ~filt;
    chk({tag, " wb_en_load"}, tensor_wb_write_en, 1);
    chk({tag, " busy_load"}, busy, 1);
    @(posedge clk);
    #1;
    chk({tag, " wb_en_run"}, tensor_wb_write_en, 0);
  endtask

  task automatic wait_iss(input string tag, input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2;
      if (iss_row_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, " issue_wait"}, ok, 1);
  endtask

  task automatic check_pass(input string tag, input int rb, input int ib, input int db,
                            input int wb, input int mode);
    bit seen = 1'b0;
    int bad_d = 0, bad_l = 0, bad_a = 0;
    int ex;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #2;
      if (done_cnt > db) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, " done_seen"}, seen, 1);
    @(posedge clk);
    #2;
    chk({tag, " busy_after"}, busy, 0);
    chk({tag, " done_pulses"}, done_cnt - db, 1);
    chk({tag, " n_results"}, res_q.size() - rb, NRES);
    chk({tag, " n_issues"}, iss_row_q.size() - ib, NRES);
    for (int k = 0; k < NRES; k++) begin
      ex = (mode == 0) ? 9 : 16 * (k / 6) + (k % 6);
      if (rb + k >= res_q.size()) begin
        bad_d++;
        bad_l++;
      end else begin
        if (res_q[rb + k] !== 16'(ex)) bad_d++;
        if (last_q[rb + k] !== (k == NRES - 1)) bad_l++;
      end
      if (ib + k >= iss_row_q.size()) bad_a++;
      else if (iss_row_q[ib + k] != k / 6 || iss_col_q[ib + k] != k % 6) bad_a++;
    end
    chk({tag, " bad_data"}, bad_d, 0);
    chk({tag, " bad_last"}, bad_l, 0);
    chk({tag, " bad_addr"}, bad_a, 0);
    chk({tag, " done_after_last"}, done_cyc > last_pop_cyc, 1);
    chk({tag, " wb_cycles"}, wb_cnt - wb, 1);
  endtask

  initial begin
    int rb, ib, db, wb;
    rst       = 1'b0;
    start     = 1'b0;
    filter_in = '0;
    out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst win_req", win_req, 0);
    chk("rst wb_en", tensor_wb_write_en, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_last", out_last, 0);
    chk("rst win_addr", {win_row, win_col}, 0);
    chk("rst out_data", out_data, 0);
    chk("rst filter", tensor_filter, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("idle busy", busy, 0);

    // basic pass: ones filter, ones windows
    psum_mode = 0;
    rb = res_q.size(); ib = iss_row_q.size(); db = done_cnt; wb = wb_cnt;
    start_pass("basic", F1);
    chk("basic filter", tensor_filter, F1);
    check_pass("basic", rb, ib, db, wb, 0);

    // raster order via encoded window index
    psum_mode = 1;
    rb = res_q.size(); ib = iss_row_q.size(); db = done_cnt; wb = wb_cnt;
    start_pass("raster", F1);
    check_pass("raster", rb, ib, db, wb, 1);

    // backpressure for 20 cycles mid-RUN
    rb = res_q.size(); ib = iss_row_q.size(); db = done_cnt; wb = wb_cnt;
    start_pass("bp", F1);
    wait_iss("bp", ib + 8);
    out_ready = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("bp win_req_low", win_req, 0);
    chk("bp outstanding", outst, FD);
    out_ready = 1'b1;
    check_pass("bp", rb, ib, db, wb, 1);

    // random win_ack stalls
    ack_rnd = 1'b1;
    psum_mode = 0;
    rb = res_q.size(); ib = iss_row_q.size(); db = done_cnt; wb = wb_cnt;
    start_pass("stall", F1);
    check_pass("stall", rb, ib, db, wb, 0);
    psum_mode = 1;
    rb = res_q.size(); ib = iss_row_q.size(); db = done_cnt; wb = wb_cnt;
    start_pass("stall_idx", F1);
    check_pass("stall_idx", rb, ib, db, wb, 1);
    chk("stall hold_addr", hold_err, 0);
    ack_rnd = 1'b0;

    // start while busy is ignored
    psum_mode = 0;
    rb = res_q.size(); ib = iss_row_q.size(); db = done_cnt; wb = wb_cnt;
    start_pass("busy_start", F1);
    wait_iss("busy_start", ib + 5);
    start     = 1'b1;
    filter_in = F2;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_start filter", tensor_filter, F1);
    check_pass("busy_start", rb, ib, db, wb, 0);

    // asynchronous reset at the 10th issue, then a clean pass
    psum_mode = 1;
    ib = iss_row_q.size(); db = done_cnt;
    start_pass("abort", F2);
    wait_iss("abort", ib + 10);
    rst = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort win_req", win_req, 0);
    chk("abort out_valid", out_valid, 0);
    chk("abort wb_en", tensor_wb_write_en, 0);
    chk("abort filter", tensor_filter, 0);
    chk("abort win_addr", {win_row, win_col}, 0);
    chk("abort out_data_last", {out_last, out_data}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("abort no_done", done_cnt - db, 0);
    rb = res_q.size(); ib = iss_row_q.size(); db = done_cnt; wb = wb_cnt;
    start_pass("after_rst", F1);
    check_pass("after_rst", rb, ib, db, wb, 1);

    chk("fifo_no_overflow", ovf_flag, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
